ex_muldiv_seq: RTL and testbench

Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU in the EX stage, owning the HI/LO register pair.
- Accepts one operation from the EX stage and stalls the pipeline while it runs.
- Iterates a radix-2 shift-add multiply or restoring divide step, 32 steps per operation.
- Handles MTHI/MTLO writes and exposes HI/LO continuously for the MFHI/MFLO result mux beside the ALU.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_step.sv | 35 +++
 rtl/ex_muldiv_seq.sv | 190 +++++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the EX-stage HI/LO multiply/divide sequencer:
// funct codes, FSM state encoding and default widths.
package muldiv_pkg;

   localparam int NB_DATA_DEF  = 32;
   localparam int NB_FUNCT_DEF = 6;

   localparam logic [NB_FUNCT_DEF-1:0] FUNCT_MTHI  = 6'b010001;
   localparam logic [NB_FUNCT_DEF-1:0] FUNCT_MTLO  = 6'b010011;
   localparam logic [NB_FUNCT_DEF-1:0] FUNCT_MULT  = 6'b011000;
   localparam logic [NB_FUNCT_DEF-1:0] FUNCT_MULTU = 6'b011001;
   localparam logic [NB_FUNCT_DEF-1:0] FUNCT_DIV   = 6'b011010;
   localparam logic [NB_FUNCT_DEF-1:0] FUNCT_DIVU  = 6'b011011;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PREP = 3'd1;
   localparam logic [2:0] ST_RUN  = 3'd2;
   localparam logic [2:0] ST_FIX  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   function automatic logic is_muldiv(input logic [NB_FUNCT_DEF-1:0] funct);
      return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
             (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide
// on the {acc, shreg} pair. Purely combinational.
module muldiv_step #(
   parameter int NB_DATA = 32
) (
   input  logic [NB_DATA-1:0] i_acc,
   input  logic [NB_DATA-1:0] i_shreg,
   input  logic [NB_DATA-1:0] i_operand,
   input  logic               i_is_div,
   output logic [NB_DATA-1:0] o_acc,
   output logic [NB_DATA-1:0] o_shreg
);

   logic [NB_DATA:0]   mul_sum;
   logic [NB_DATA:0]   rem_shift;
   logic [NB_DATA-1:0] rem_diff;
   logic               rem_ge;

   always_comb begin
      mul_sum   = {1'b0, i_acc} + (i_shreg[0] ? {1'b0, i_operand} : '0);
      rem_shift = {i_acc, i_shreg[NB_DATA-1]};
      rem_ge    = (rem_shift >= {1'b0, i_operand});
      // When the subtraction is kept the true difference is below the divisor,
      // so the low NB_DATA bits hold it exactly.
      rem_diff  = rem_shift[NB_DATA-1:0] - i_operand;
      if (i_is_div) begin
         o_acc   = rem_ge ? rem_diff : rem_shift[NB_DATA-1:0];
         o_shreg = {i_shreg[NB_DATA-2:0], rem_ge};
      end else begin
         o_acc   = mul_sum[NB_DATA:1];
         o_shreg = {mul_sum[0], i_shreg[NB_DATA-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv_seq.sv
// EX-stage MULT/MULTU/DIV/DIVU sequencer owning HI/LO; stalls the pipe while busy.
// Define MULDIV_EARLY_TERM_EN to finish multiplies once no multiplier bits remain.
module ex_muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int NB_DATA  = NB_DATA_DEF,
   parameter int NB_FUNCT = NB_FUNCT_DEF
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic [NB_FUNCT-1:0] i_funct,
   input  logic [NB_DATA-1:0]  i_op_a,
   input  logic [NB_DATA-1:0]  i_op_b,
   input  logic                i_flush,
   output logic                o_stall,
   output logic [NB_DATA-1:0]  o_hi,
   output logic [NB_DATA-1:0]  o_lo,
   output logic                o_done,
   output logic                o_div_by_zero
);

   localparam int NB_CNT = $clog2(NB_DATA);
   localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_DATA - 1);

   logic [2:0]          state_q, state_d;
   logic [NB_CNT-1:0]   cnt_q, cnt_d;
   logic [NB_FUNCT-1:0] funct_q, funct_d;
   logic [NB_DATA-1:0]  a_q, a_d, b_q, b_d;
   logic [NB_DATA-1:0]  acc_q, acc_d, shreg_q, shreg_d, opnd_q, opnd_d;
   logic [NB_DATA-1:0]  hi_q, hi_d, lo_q, lo_d;
   logic                neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
   logic                dbz_q, dbz_d;

   logic                accept, is_div, is_signed;
   logic [NB_DATA-1:0]  a_abs, b_abs, step_acc, step_shreg, quot_fix, rem_fix;
   logic [2*NB_DATA-1:0] prod_fix;

   assign accept    = (state_q == ST_IDLE) && i_start && is_muldiv(i_funct) && !i_flush;
   assign is_div    = (funct_q == FUNCT_DIV)  || (funct_q == FUNCT_DIVU);
   assign is_signed = (funct_q == FUNCT_MULT) || (funct_q == FUNCT_DIV);
   assign a_abs     = (is_signed && a_q[NB_DATA-1]) ? -a_q : a_q;
   assign b_abs     = (is_signed && b_q[NB_DATA-1]) ? -b_q : b_q;
   assign prod_fix  = neg_res_q ? -{acc_q, shreg_q} : {acc_q, shreg_q};
   assign quot_fix  = neg_res_q ? -shreg_q : shreg_q;
   assign rem_fix   = neg_rem_q ? -acc_q : acc_q;

   muldiv_step #(.NB_DATA(NB_DATA)) u_step (
      .i_acc     (acc_q),
      .i_shreg   (shreg_q),
      .i_operand (opnd_q),
      .i_is_div  (is_div),
      .o_acc     (step_acc),
      .o_shreg   (step_shreg)
   );

`ifdef MULDIV_EARLY_TERM_EN
   logic [NB_DATA-1:0]   remain_mask;
   logic [NB_CNT:0]      remain_cnt;
   logic [2*NB_DATA-1:0] aligned;
   logic                 early_done;

   // Low (NB_DATA - cnt) bits of shreg are the multiplier bits not yet consumed.
   assign remain_mask = {NB_DATA{1'b1}} >> cnt_q;
   assign remain_cnt  = (NB_CNT+1)'(NB_DATA) - {1'b0, cnt_q};
   assign aligned     = {acc_q, shreg_q} >> remain_cnt;
   assign early_done  = !is_div && ((shreg_q & remain_mask) == '0);
`endif

   // NOTE: every next-state signal gets its hold value first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      funct_d   = funct_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      shreg_d   = shreg_q;
      opnd_d    = opnd_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_PREP;
               funct_d = i_funct;
               a_d     = i_op_a;
               b_d     = i_op_b;
            end else if (i_start && (i_funct == FUNCT_MTHI)) begin
               hi_d = i_op_a;
            end else if (i_start && (i_funct == FUNCT_MTLO)) begin
               lo_d = i_op_a;
            end
         end
         ST_PREP: begin
            cnt_d     = '0;
            acc_d     = '0;
            shreg_d   = is_div ? a_abs : b_abs;
            opnd_d    = is_div ? b_abs : a_abs;
            neg_res_d = is_signed && (a_q[NB_DATA-1] ^ b_q[NB_DATA-1]);
            neg_rem_d = is_signed && a_q[NB_DATA-1];
            dbz_d     = is_div && (b_q == '0);
            if (i_flush) begin
               state_d = ST_IDLE;
            end else if (is_div && (b_q == '0)) begin
               hi_d    = a_q;
               lo_d    = '1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (i_flush) begin
               state_d = ST_IDLE;
`ifdef MULDIV_EARLY_TERM_EN
            end else if (early_done) begin
               {acc_d, shreg_d} = aligned;
               state_d          = ST_FIX;
`endif
            end else begin
               acc_d   = step_acc;
               shreg_d = step_shreg;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            if (i_flush) begin
               state_d = ST_IDLE;
            end else begin
               if (is_div) begin
                  hi_d = rem_fix;
                  lo_d = quot_fix;
               end else begin
                  {hi_d, lo_d} = prod_fix;
               end
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; datapath flops
   // are reset as well so nothing powers up undefined.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         funct_q   <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         shreg_q   <= '0;
         opnd_q    <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         funct_q   <= funct_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         shreg_q   <= shreg_d;
         opnd_q    <= opnd_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign o_stall       = accept || (state_q == ST_PREP) || (state_q == ST_RUN) ||
                          (state_q == ST_FIX);
   assign o_done        = (state_q == ST_DONE);
   assign o_div_by_zero = o_done && dbz_q;
   assign o_hi          = hi_q;
   assign o_lo          = lo_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed self-checking bench for ex_muldiv_seq: table of mul/div vectors run
// back-to-back, plus MTHI/MTLO, flush and mid-operation reset sequences.
module tb_ex_muldiv_seq;
   import muldiv_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_start;
   logic [5:0]  i_funct;
   logic [31:0] i_op_a;
   logic [31:0] i_op_b;
   logic        i_flush;
   logic        o_stall;
   logic [31:0] o_hi;
   logic [31:0] o_lo;
   logic        o_done;
   logic        o_div_by_zero;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0]  funct;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } vec_t;

   vec_t vecs[12];

   ex_muldiv_seq dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_start       (i_start),
      .i_funct       (i_funct),
      .i_op_a        (i_op_a),
      .i_op_b        (i_op_b),
      .i_flush       (i_flush),
      .o_stall       (o_stall),
      .o_hi          (o_hi),
      .o_lo          (o_lo),
      .o_done        (o_done),
      .o_div_by_zero (o_div_by_zero)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Cycle at which o_done is expected, counting the accept cycle as 0.
   function automatic int exp_done_cycle(input logic [5:0] f, input logic [31:0] b,
                                         input logic dbz);
      logic [31:0] b_mag;
      int          msb;
      if (dbz) return 2;
      if ((f == FUNCT_DIV) || (f == FUNCT_DIVU)) return 35;
`ifdef MULDIV_EARLY_TERM_EN
      b_mag = ((f == FUNCT_MULT) && b[31]) ? -b : b;
      msb   = -1;
      for (int i = 0; i < 32; i++) if (b_mag[i]) msb = i;
      return (5 + msb < 35) ? 5 + msb : 35;
`else
      b_mag = b;
      msb   = 0;
      return 35 + msb * 0 + int'(b_mag[0] & 1'b0);
`endif
   endfunction

   // Starts an op in the current cycle, holds it until DONE, then drops i_start.
   task automatic run_op(input string nm, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dbz);
      int   done_cyc;
      int   stall_cnt;
      int   exp_cyc;
      logic dbz_seen;
      done_cyc  = -1;
      stall_cnt = 0;
      dbz_seen  = 1'b0;
      exp_cyc   = exp_done_cycle(f, b, exp_dbz);
      i_start   = 1'b1;
      i_funct   = f;
      i_op_a    = a;
      i_op_b    = b;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (o_stall) stall_cnt++;
         if (o_done) begin
            done_cyc = c;
            dbz_seen = o_div_by_zero;
            break;
         end
         @(posedge i_clk);
         #1;
      end
      check({nm, " done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
      check({nm, " stall_cycles"}, 64'(stall_cnt), 64'(exp_cyc));
      check({nm, " hi"}, {32'h0, o_hi}, {32'h0, exp_hi});
      check({nm, " lo"}, {32'h0, o_lo}, {32'h0, exp_lo});
      check({nm, " div_by_zero"}, {63'h0, dbz_seen}, {63'h0, exp_dbz});
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      #1;
      check({nm, " done_pulse"}, {63'h0, o_done}, 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic saw_done;
      vecs[0]  = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[1]  = '{FUNCT_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[2]  = '{FUNCT_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[3]  = '{FUNCT_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
      vecs[4]  = '{FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[5]  = '{FUNCT_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
      vecs[6]  = '{FUNCT_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0};
      vecs[7]  = '{FUNCT_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
      vecs[8]  = '{FUNCT_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[9]  = '{FUNCT_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
      vecs[10] = '{FUNCT_DIVU,  32'd3,        32'd0,        32'd3,        32'hFFFFFFFF, 1'b1};
      vecs[11] = '{FUNCT_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};

      i_rst_n = 1'b0;
      i_start = 1'b0;
      i_funct = '0;
      i_op_a  = '0;
      i_op_b  = '0;
      i_flush = 1'b0;
      #12;
      check("reset hi", {32'h0, o_hi}, 64'h0);
      check("reset lo", {32'h0, o_lo}, 64'h0);
      check("reset stall", {63'h0, o_stall}, 64'h0);
      check("reset done", {63'h0, o_done}, 64'h0);
      check("reset dbz", {63'h0, o_div_by_zero}, 64'h0);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      // Back-to-back: each op starts in the first IDLE cycle after the previous DONE.
      for (int i = 0; i < 12; i++)
         run_op($sformatf("vec%0d", i), vecs[i].funct, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo, vecs[i].dbz);

      // MTHI then MTLO on consecutive cycles: no stall, visible the next cycle.
      @(posedge i_clk);
      #1;
      i_start = 1'b1;
      i_funct = FUNCT_MTHI;
      i_op_a  = 32'h1234;
      #1;
      check("mthi stall", {63'h0, o_stall}, 64'h0);
      @(posedge i_clk);
      #1;
      check("mthi hi", {32'h0, o_hi}, 64'h1234);
      i_funct = FUNCT_MTLO;
      i_op_a  = 32'hABCD;
      #1;
      check("mtlo stall", {63'h0, o_stall}, 64'h0);
      check("mthi done", {63'h0, o_done}, 64'h0);
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      check("mtlo lo", {32'h0, o_lo}, 64'hABCD);
      check("mtlo hi kept", {32'h0, o_hi}, 64'h1234);

      // Flush at cycle 10 of a MULT leaves HI/LO untouched and never pulses done.
      i_start = 1'b1;
      i_funct = FUNCT_MTHI;
      i_op_a  = 32'h11;
      @(posedge i_clk);
      #1;
      i_funct = FUNCT_MTLO;
      i_op_a  = 32'h22;
      @(posedge i_clk);
      #1;
      i_funct = FUNCT_MULT;
      i_op_a  = 32'hFFFFFFFD;
      i_op_b  = 32'd7;
      for (int c = 1; c <= 10; c++) begin
         @(posedge i_clk);
         #1;
      end
      i_flush = 1'b1;
      #1;
      check("flush stall_before", {63'h0, o_stall}, 64'h1);
      @(posedge i_clk);
      #1;
      i_flush = 1'b0;
      i_start = 1'b0;
      #1;
      check("flush stall", {63'h0, o_stall}, 64'h0);
      check("flush hi", {32'h0, o_hi}, 64'h11);
      check("flush lo", {32'h0, o_lo}, 64'h22);
      saw_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge i_clk);
         #1;
         if (o_done || o_stall) saw_done = 1'b1;
      end
      check("flush no_done", {63'h0, saw_done}, 64'h0);
      check("flush hi_later", {32'h0, o_hi}, 64'h11);

      // Asynchronous reset at cycle 20 of a MULT clears outputs immediately.
      i_start = 1'b1;
      i_funct = FUNCT_MULT;
      i_op_a  = 32'hFFFFFFFD;
      i_op_b  = 32'd7;
      for (int c = 1; c <= 20; c++) begin
         @(posedge i_clk);
         #1;
      end
      #2;
      i_rst_n = 1'b0;
      i_start = 1'b0;
      #1;
      check("arst hi", {32'h0, o_hi}, 64'h0);
      check("arst lo", {32'h0, o_lo}, 64'h0);
      check("arst stall", {63'h0, o_stall}, 64'h0);
      check("arst done", {63'h0, o_done}, 64'h0);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      run_op("multu_6x7", FUNCT_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
      run_op("multu_5x3", FUNCT_MULTU, 32'd5, 32'd3, 32'd0, 32'd15, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
